// File: rtl/ex_pkg.sv
// Shared pipeline definitions for the execute stage: ALU op encodings,
// bubble constants, EX/MEM entry layout and multiply/divide FSM states.
package ex_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_NOR   = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_MULT  = 4'd10;
    localparam logic [3:0] ALU_MULTU = 4'd11;
    localparam logic [3:0] ALU_DIV   = 4'd12;
    localparam logic [3:0] ALU_DIVU  = 4'd13;
    localparam logic [3:0] ALU_MFHI  = 4'd14;
    localparam logic [3:0] ALU_MFLO  = 4'd15;

    localparam logic [31:0] BUBBLE_DATA = 32'd0;
    localparam logic [4:0]  BUBBLE_RD   = 5'd0;
    localparam logic [6:0]  BUBBLE_MUX  = 7'd0;
    localparam logic [2:0]  BUBBLE_MEM  = 3'd0;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_RUN  = 2'd1;
    localparam logic [1:0] MD_FIX  = 2'd2;

    // RUN spends its first cycle preparing operand magnitudes, then iterates.
    localparam logic [5:0] MD_ITERS = 6'd32;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic [6:0]  muxctrl;
        logic [2:0]  memctrl;
    } ex_mem_t;

    localparam ex_mem_t EX_MEM_BUBBLE = '{
        alu: BUBBLE_DATA, d2: BUBBLE_DATA, rd: BUBBLE_RD,
        muxctrl: BUBBLE_MUX, memctrl: BUBBLE_MEM
    };

    function automatic logic is_md_start_op(input logic [3:0] op);
        return (op >= ALU_MULT) && (op <= ALU_DIVU);
    endfunction

    function automatic logic uses_md(input logic [3:0] op);
        return op >= ALU_MULT;
    endfunction

endpackage

// File: rtl/ex_stage_muldiv.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply and
// restoring divide on magnitudes, with sign correction in a final FIX cycle.
module muldiv_unit
    import ex_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start_in,
    input  logic        div_in,
    input  logic        unsigned_in,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy_out,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [1:0]  state_out
);

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        div_q, div_d;
    logic        uns_q, uns_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic [31:0] mag_b_q, mag_b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        neg_a, neg_b;
    logic [32:0] shifted, trial, sum;
    logic [63:0] prod;

    assign neg_a = !uns_q && a_q[31];
    assign neg_b = !uns_q && b_q[31];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        uns_d    = uns_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mag_b_d  = mag_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        shifted  = {acc_hi_q, acc_lo_q[31]};
        trial    = shifted - {1'b0, mag_b_q};
        sum      = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : 33'd0);
        prod     = {acc_hi_q, acc_lo_q};

        case (state_q)
            MD_IDLE: begin
                if (start_in) begin
                    state_d = MD_RUN;
                    cnt_d   = 6'd0;
                    div_d   = div_in;
                    uns_d   = unsigned_in;
                    a_d     = a_in;
                    b_d     = b_in;
                end
            end
            MD_RUN: begin
                if (cnt_q == 6'd0) begin
                    acc_hi_d = 32'd0;
                    acc_lo_d = neg_a ? -a_q : a_q;
                    mag_b_d  = neg_b ? -b_q : b_q;
                end else if (div_q) begin
                    // Restoring step: keep the trial remainder only when non-negative.
                    if (!trial[32]) begin
                        acc_hi_d = trial[31:0];
                        acc_lo_d = {acc_lo_q[30:0], 1'b1};
                    end else begin
                        acc_hi_d = shifted[31:0];
                        acc_lo_d = {acc_lo_q[30:0], 1'b0};
                    end
                end else begin
                    {acc_hi_d, acc_lo_d} = {sum, acc_lo_q[31:1]};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == MD_ITERS) state_d = MD_FIX;
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                if (div_q) begin
                    if (b_q == 32'd0) begin
                        hi_d = a_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        lo_d = (neg_a ^ neg_b) ? -acc_lo_q : acc_lo_q;
                        hi_d = neg_a ? -acc_hi_q : acc_hi_q;
                    end
                end else begin
                    if (neg_a ^ neg_b) prod = -prod;
                    {hi_d, lo_d} = prod;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= MD_IDLE;
            cnt_q    <= 6'd0;
            div_q    <= 1'b0;
            uns_q    <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            acc_hi_q <= 32'd0;
            acc_lo_q <= 32'd0;
            mag_b_q  <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            uns_q    <= uns_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mag_b_q  <= mag_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy_out  = (state_q != MD_IDLE);
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign state_out = state_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU feeding the EX/MEM register, plus the
// multi-cycle multiply/divide unit with stall and flush handling.
module ex_stage
    import ex_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] d1_in,
    input  logic [31:0] d2_in,
    input  logic [4:0]  rd_in,
    input  logic [6:0]  muxctrl_in,
    input  logic [2:0]  memctrl_in,
    input  logic [3:0]  aluctrl_in,
    input  logic        flush_in,
    output logic [31:0] alu_out,
    output logic [31:0] d2_out,
    output logic [4:0]  rd_out,
    output logic [6:0]  muxctrl_out,
    output logic [2:0]  memctrl_out,
    output logic        stall_out,
    output logic        md_busy,
    output logic [1:0]  md_state_dbg
);

    ex_mem_t     ex_mem_q, ex_mem_d;
    logic [31:0] alu_result;
    logic [31:0] hi, lo;
    logic        md_start;
    logic        bubble;

    // Hold request only when a HI/LO-touching op meets a busy unit.
    assign stall_out = md_busy && uses_md(aluctrl_in);
    assign md_start  = !flush_in && !md_busy && is_md_start_op(aluctrl_in);
    assign bubble    = flush_in || stall_out || is_md_start_op(aluctrl_in);

    always_comb begin
        alu_result = 32'd0;
        case (aluctrl_in)
            ALU_ADD:  alu_result = d1_in + d2_in;
            ALU_SUB:  alu_result = d1_in - d2_in;
            ALU_AND:  alu_result = d1_in & d2_in;
            ALU_OR:   alu_result = d1_in | d2_in;
            ALU_XOR:  alu_result = d1_in ^ d2_in;
            ALU_NOR:  alu_result = ~(d1_in | d2_in);
            ALU_SLT:  alu_result = {31'd0, $signed(d1_in) < $signed(d2_in)};
            ALU_SLL:  alu_result = d2_in << d1_in[4:0];
            ALU_SRL:  alu_result = d2_in >> d1_in[4:0];
            ALU_SRA:  alu_result = $unsigned($signed(d2_in) >>> d1_in[4:0]);
            ALU_MFHI: alu_result = hi;
            ALU_MFLO: alu_result = lo;
            default:  alu_result = 32'd0;
        endcase
    end

    always_comb begin
        ex_mem_d = EX_MEM_BUBBLE;
        if (!bubble) begin
            ex_mem_d.alu     = alu_result;
            ex_mem_d.d2      = d2_in;
            ex_mem_d.rd      = rd_in;
            ex_mem_d.muxctrl = muxctrl_in;
            ex_mem_d.memctrl = memctrl_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ex_mem_q <= EX_MEM_BUBBLE;
        else        ex_mem_q <= ex_mem_d;
    end

    muldiv_unit u_muldiv (
        .clock       (clock),
        .reset       (reset),
        .start_in    (md_start),
        .div_in      (aluctrl_in[2]),
        .unsigned_in (aluctrl_in[0]),
        .a_in        (d1_in),
        .b_in        (d2_in),
        .busy_out    (md_busy),
        .hi_out      (hi),
        .lo_out      (lo),
        .state_out   (md_state_dbg)
    );

    assign alu_out     = ex_mem_q.alu;
    assign d2_out      = ex_mem_q.d2;
    assign rd_out      = ex_mem_q.rd;
    assign muxctrl_out = ex_mem_q.muxctrl;
    assign memctrl_out = ex_mem_q.memctrl;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, multiply/divide latency and results,
// stall/flush interaction and asynchronous reset.
module tb_ex_stage;
    import ex_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] d1_in = '0, d2_in = '0;
    logic [4:0]  rd_in = '0;
    logic [6:0]  muxctrl_in = '0;
    logic [2:0]  memctrl_in = '0;
    logic [3:0]  aluctrl_in = '0;
    logic        flush_in = 1'b0;
    logic [31:0] alu_out, d2_out;
    logic [4:0]  rd_out;
    logic [6:0]  muxctrl_out;
    logic [2:0]  memctrl_out;
    logic        stall_out, md_busy;
    logic [1:0]  md_state_dbg;

    int pass_cnt = 0;
    int total_cnt = 0;
    int n;
    logic bad;

    ex_stage dut (
        .clock(clock), .reset(reset),
        .d1_in(d1_in), .d2_in(d2_in), .rd_in(rd_in),
        .muxctrl_in(muxctrl_in), .memctrl_in(memctrl_in),
        .aluctrl_in(aluctrl_in), .flush_in(flush_in),
        .alu_out(alu_out), .d2_out(d2_out), .rd_out(rd_out),
        .muxctrl_out(muxctrl_out), .memctrl_out(memctrl_out),
        .stall_out(stall_out), .md_busy(md_busy), .md_state_dbg(md_state_dbg)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [6:0] mux, input logic [2:0] mem,
                         input logic fl);
        aluctrl_in = op; d1_in = a; d2_in = b; rd_in = rd;
        muxctrl_in = mux; memctrl_in = mem; flush_in = fl;
    endtask

    // Idle the stage with harmless ADDs until the unit frees up (bounded).
    task automatic wait_idle(input string tag);
        drive(ALU_ADD, 0, 0, 0, 0, 0, 0);
        n = 0;
        while (md_busy && n < 60) begin
            n++;
            tick();
        end
        check(tag, {31'd0, md_busy}, 32'd0);
    endtask

    initial begin
        // Reset state, with an MD op presented so stall must still be 0.
        drive(ALU_MULT, 32'h1, 32'h2, 5'd4, 7'h7F, 3'h7, 0);
        #2 reset = 1'b0;
        #1;
        check("rst_alu", alu_out, 32'd0);
        check("rst_rd", {27'd0, rd_out}, 32'd0);
        check("rst_busy", {31'd0, md_busy}, 32'd0);
        check("rst_stall", {31'd0, stall_out}, 32'd0);
        tick();
        reset = 1'b1;

        // Single-cycle ALU ops, latency 1 with pass-through fields.
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 5'd3, 7'h55, 3'h5, 0); tick();
        check("add_wrap", alu_out, 32'h8000_0000);
        check("add_d2", d2_out, 32'h1);
        check("add_rd", {27'd0, rd_out}, 32'd3);
        check("add_mux", {25'd0, muxctrl_out}, 32'h55);
        check("add_mem", {29'd0, memctrl_out}, 32'h5);
        drive(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 5'd1, 0, 0, 0); tick();
        check("slt", alu_out, 32'd1);
        drive(ALU_SUB, 32'd5, 32'd7, 5'd2, 0, 0, 0); tick();
        check("sub", alu_out, 32'hFFFF_FFFE);
        drive(ALU_SRA, 32'd4, 32'h8000_0000, 5'd2, 0, 0, 0); tick();
        check("sra", alu_out, 32'hF800_0000);
        drive(ALU_SRL, 32'd4, 32'h8000_0000, 5'd2, 0, 0, 0); tick();
        check("srl", alu_out, 32'h0800_0000);
        drive(ALU_SLL, 32'd31, 32'h1, 5'd2, 0, 0, 0); tick();
        check("sll", alu_out, 32'h8000_0000);
        drive(ALU_NOR, 32'h0F0F_0000, 32'h0000_00F0, 5'd2, 0, 0, 0); tick();
        check("nor", alu_out, 32'hF0F0_FF0F);
        drive(ALU_XOR, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd2, 0, 0, 0); tick();
        check("xor", alu_out, 32'hF0F0_F0F0);

        // MULT -3 x 7: bubble on accept, busy for 34 cycles.
        drive(ALU_MULT, 32'hFFFF_FFFD, 32'd7, 5'd8, 7'h11, 3'h1, 0); tick();
        check("mult_bubble", alu_out, 32'd0);
        check("mult_bubble_rd", {27'd0, rd_out}, 32'd0);
        check("mult_state", {30'd0, md_state_dbg}, {30'd0, MD_RUN});
        drive(ALU_ADD, 0, 0, 0, 0, 0, 0);
        n = 0;
        while (md_busy && n < 60) begin
            n++;
            tick();
        end
        check("mult_busy_cycles", n, 34);
        drive(ALU_MFLO, 0, 0, 5'd1, 0, 0, 0); tick();
        check("mult_lo", alu_out, 32'hFFFF_FFEB);
        drive(ALU_MFHI, 0, 0, 5'd1, 0, 0, 0); tick();
        check("mult_hi", alu_out, 32'hFFFF_FFFF);

        // DIV -7 / 2, then DIVU 5 / 0.
        drive(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0); tick();
        wait_idle("div_done");
        drive(ALU_MFLO, 0, 0, 5'd1, 0, 0, 0); tick();
        check("div_lo", alu_out, 32'hFFFF_FFFD);
        drive(ALU_MFHI, 0, 0, 5'd1, 0, 0, 0); tick();
        check("div_hi", alu_out, 32'hFFFF_FFFF);
        drive(ALU_DIVU, 32'd5, 32'd0, 0, 0, 0, 0); tick();
        wait_idle("divz_done");
        drive(ALU_MFHI, 0, 0, 5'd1, 0, 0, 0); tick();
        check("divz_hi", alu_out, 32'd5);
        drive(ALU_MFLO, 0, 0, 5'd1, 0, 0, 0); tick();
        check("divz_lo", alu_out, 32'hFFFF_FFFF);

        // MULTU 0x10000 x 0x30000 = 0x3_0000_0000; ADD during busy, then MFHI stalls.
        drive(ALU_MULTU, 32'h0001_0000, 32'h0003_0000, 0, 0, 0, 0); tick();
        drive(ALU_ADD, 32'd1, 32'd2, 5'd9, 0, 0, 0); tick();
        check("busy_add", alu_out, 32'd3);
        check("busy_add_rd", {27'd0, rd_out}, 32'd9);
        check("busy_add_busy", {31'd0, md_busy}, 32'd1);
        drive(ALU_MFHI, 0, 0, 5'd6, 0, 0, 0);
        #1;
        check("mfhi_stall", {31'd0, stall_out}, 32'd1);
        n = 0;
        bad = 1'b0;
        while (stall_out && n < 60) begin
            n++;
            tick();
            if (alu_out !== 32'd0 || rd_out !== 5'd0) bad = 1'b1;
        end
        check("stall_bubbles", {31'd0, bad}, 32'd0);
        check("stall_released", {31'd0, stall_out}, 32'd0);
        tick();
        check("mfhi_after_stall", alu_out, 32'd3);
        check("mfhi_after_stall_rd", {27'd0, rd_out}, 32'd6);

        // Flush with MULT: bubble, no start.
        drive(ALU_MULT, 32'd2, 32'd3, 5'd5, 0, 0, 1); tick();
        check("flush_mult_alu", alu_out, 32'd0);
        check("flush_mult_busy", {31'd0, md_busy}, 32'd0);
        // Flush during busy does not abort; flush plus stall gives one bubble.
        drive(ALU_MULT, 32'd2, 32'd3, 5'd5, 0, 0, 0); tick();
        drive(ALU_ADD, 32'd1, 32'd1, 5'd5, 0, 0, 1); tick();
        check("flush_busy_alu", alu_out, 32'd0);
        check("flush_busy_busy", {31'd0, md_busy}, 32'd1);
        drive(ALU_MFLO, 0, 0, 5'd5, 0, 0, 1);
        #1;
        check("flush_stall", {31'd0, stall_out}, 32'd1);
        tick();
        check("flush_stall_alu", alu_out, 32'd0);
        wait_idle("flush_busy_done");
        drive(ALU_MFLO, 0, 0, 5'd1, 0, 0, 0); tick();
        check("flush_busy_lo", alu_out, 32'd6);

        // Reset mid-RUN.
        drive(ALU_MULT, 32'd5, 32'd5, 0, 0, 0, 0); tick();
        drive(ALU_ADD, 32'd1, 32'd2, 5'd7, 7'h3, 3'h2, 0); tick();
        check("pre_rst_alu", alu_out, 32'd3);
        tick(); tick();
        #2 reset = 1'b0;
        #1;
        check("mid_rst_alu", alu_out, 32'd0);
        check("mid_rst_mux", {25'd0, muxctrl_out}, 32'd0);
        check("mid_rst_busy", {31'd0, md_busy}, 32'd0);
        tick();
        reset = 1'b1;
        n = 0;
        repeat (40) begin
            tick();
            if (md_busy) n++;
        end
        check("post_rst_idle", n, 0);
        drive(ALU_MFLO, 0, 0, 5'd1, 0, 0, 0); tick();
        check("post_rst_lo", alu_out, 32'd0);
        drive(ALU_MFHI, 0, 0, 5'd1, 0, 0, 0); tick();
        check("post_rst_hi", alu_out, 32'd0);
        check("post_rst_hi_rd", {27'd0, rd_out}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
